// File: rtl/wb_watchdog_pkg.sv
// Shared types and widths for the Wishbone watchdog bridge.
// Holds the bridge state encoding, bus widths and status-counter helpers.
package wb_watchdog_pkg;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } wb_state_e;

   // Status counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/wb_watchdog_bridge.sv
// Single-outstanding Wishbone bridge that terminates hung downstream cycles with an error
// and rejects out-of-range addresses locally, keeping saturating counts of both events.
module wb_watchdog_bridge
   import wb_watchdog_pkg::*;
#(
   parameter int unsigned TIMEOUT_CLKS = 1024,
   parameter logic [31:0] ADDR_LIMIT   = 32'hFFFF_FFFF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_up_cyc,
   input  logic             i_up_stb,
   input  logic             i_up_we,
   input  logic [WB_AW-1:0] i_up_addr,
   input  logic [WB_DW-1:0] i_up_data,
   output logic             o_up_ack,
   output logic             o_up_err,
   output logic             o_up_stall,
   output logic [WB_DW-1:0] o_up_data,
   output logic             o_dn_cyc,
   output logic             o_dn_stb,
   output logic             o_dn_we,
   output logic [WB_AW-1:0] o_dn_addr,
   output logic [WB_DW-1:0] o_dn_data,
   input  logic             i_dn_ack,
   input  logic             i_dn_err,
   input  logic             i_dn_stall,
   input  logic [WB_DW-1:0] i_dn_data,
   output logic [CNT_W-1:0] o_timeout_count,
   output logic [CNT_W-1:0] o_reject_count
);

   localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

   wb_state_e        state, state_nxt;
   logic [TW-1:0]    tcnt;
   logic             lat_we;
   logic [WB_AW-1:0] lat_addr;
   logic [WB_DW-1:0] lat_data;
   logic [WB_DW-1:0] rsp_data;
   logic             rsp_err;
   logic [CNT_W-1:0] to_cnt, rej_cnt;
   logic             start, reject, capture, expire;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Priority in REQ/WAIT: upstream abort, then slave response, then expiry, then acceptance.
   always_comb begin
      state_nxt  = state;
      start      = 1'b0;
      reject     = 1'b0;
      capture    = 1'b0;
      expire     = 1'b0;
      o_up_stall = 1'b1;
      o_up_ack   = 1'b0;
      o_up_err   = 1'b0;
      o_dn_cyc   = 1'b0;
      o_dn_stb   = 1'b0;
      case (state)
         IDLE: begin
            o_up_stall = 1'b0;
            if (i_up_cyc && i_up_stb) begin
               if (i_up_addr < ADDR_LIMIT) begin
                  start     = 1'b1;
                  state_nxt = REQ;
               end else begin
                  reject    = 1'b1;
                  state_nxt = RESP;
               end
            end
         end
         REQ, WAIT: begin
            o_dn_cyc = 1'b1;
            o_dn_stb = (state == REQ);
            if (!i_up_cyc) begin
               state_nxt = IDLE;
            end else if (i_dn_ack || i_dn_err) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else if (tcnt == T_LAST) begin
               expire    = 1'b1;
               state_nxt = RESP;
            end else if (state == REQ && !i_dn_stall) begin
               state_nxt = WAIT;
            end
         end
         RESP: begin
            o_up_ack  = i_up_cyc && !rsp_err;
            o_up_err  = i_up_cyc && rsp_err;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tcnt     <= '0;
         lat_we   <= 1'b0;
         lat_addr <= '0;
         lat_data <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
         to_cnt   <= '0;
         rej_cnt  <= '0;
      end else begin
         if (start) begin
            lat_we   <= i_up_we;
            lat_addr <= i_up_addr;
            lat_data <= i_up_data;
            tcnt     <= '0;
         end else if (state == REQ || state == WAIT) begin
            tcnt <= tcnt + 1'b1;
         end
         // Error wins over a simultaneous ack, and error responses never carry data.
         if (capture) begin
            rsp_err  <= i_dn_err;
            rsp_data <= i_dn_err ? '0 : i_dn_data;
         end else if (reject || expire) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
         end
         if (reject) rej_cnt <= sat_inc(rej_cnt);
         if (expire) to_cnt  <= sat_inc(to_cnt);
      end
   end

   assign o_up_data       = o_up_ack ? rsp_data : '0;
   assign o_dn_we         = lat_we;
   assign o_dn_addr       = lat_addr;
   assign o_dn_data       = lat_data;
   assign o_timeout_count = to_cnt;
   assign o_reject_count  = rej_cnt;

endmodule

// File: tb/tb_wb_watchdog_bridge.sv
// Bench for wb_watchdog_bridge: RAM slave with stall/error injection, transaction-level
// reference model computing response type, timing and counters from the bridge rules.
module tb_wb_watchdog_bridge;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        up_cyc = 1'b0, up_stb = 1'b0, up_we = 1'b0;
   logic [31:0] up_addr = '0, up_wdata = '0;
   logic        up_ack, up_err, up_stall;
   logic [31:0] up_rdata;
   logic        dn_cyc, dn_stb, dn_we;
   logic [31:0] dn_addr, dn_wdata;
   logic        dn_ack = 1'b0, dn_err = 1'b0, dn_stall = 1'b0;
   logic [31:0] dn_rdata = '0;
   logic [15:0] to_cnt, rej_cnt;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] ram [128];
   logic [31:0] mem_model [128];
   logic [31:0] exp_q [$];
   int          exp_to = 0;
   int          exp_rej = 0;

   wb_watchdog_bridge #(.TIMEOUT_CLKS(TO), .ADDR_LIMIT(32'd128)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_up_cyc(up_cyc), .i_up_stb(up_stb), .i_up_we(up_we),
      .i_up_addr(up_addr), .i_up_data(up_wdata),
      .o_up_ack(up_ack), .o_up_err(up_err), .o_up_stall(up_stall), .o_up_data(up_rdata),
      .o_dn_cyc(dn_cyc), .o_dn_stb(dn_stb), .o_dn_we(dn_we),
      .o_dn_addr(dn_addr), .o_dn_data(dn_wdata),
      .i_dn_ack(dn_ack), .i_dn_err(dn_err), .i_dn_stall(dn_stall), .i_dn_data(dn_rdata),
      .o_timeout_count(to_cnt), .o_reject_count(rej_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "bench time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_timeout_count"}, 32'(to_cnt), 32'(exp_to));
      check({tag, "_reject_count"}, 32'(rej_cnt), 32'(exp_rej));
   endtask

   // kind: 0 ack, 1 err, 2 ack+err together, 3 slave never answers.
   // The slave stalls the first stall_n REQ cycles and answers rdly cycles after accepting
   // (rdly = -1 answers in the accepting cycle itself).
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall_n, input int rdly, input int kind);
      int tr, rt, t, first, ack_n, err_n, cyc_n, stb_n, stl_n, bad_n;
      int exp_first, exp_cyc, exp_stb, exp_stl, exp_ack;
      bit reject, hit;
      reject = (addr >= 32'd128);
      tr  = stall_n + 1 + rdly;
      hit = !reject && kind != 3 && tr <= TO - 1;
      exp_ack = (hit && kind == 0) ? 1 : 0;
      if (reject) begin
         exp_first = 1; exp_cyc = 0; exp_stb = 0; exp_stl = 1;
         if (exp_rej < 65535) exp_rej++;
      end else begin
         rt = hit ? tr + 1 : TO;
         exp_first = rt + 1;
         exp_cyc   = rt;
         exp_stb   = (stall_n + 1 < rt) ? stall_n + 1 : rt;
         exp_stl   = rt + 1;
         if (!hit && exp_to < 65535) exp_to++;
         if (exp_ack == 1) begin
            if (we) mem_model[addr[6:0]] = wdata;
            exp_q.push_back(mem_model[addr[6:0]]);
         end
      end

      @(negedge clk);
      up_cyc = 1'b1; up_stb = 1'b1; up_we = we; up_addr = addr; up_wdata = wdata;
      first = -1; ack_n = 0; err_n = 0; cyc_n = 0; stb_n = 0; stl_n = 0; bad_n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (up_ack) begin
            ack_n++;
            if (first < 0) first = k;
            if (exp_q.size() > 0) check("ack_data", up_rdata, exp_q.pop_front());
         end
         if (up_err) begin
            err_n++;
            if (first < 0) first = k;
         end
         if (!up_ack && up_rdata != 32'd0) bad_n++;
         if (dn_cyc) cyc_n++;
         if (dn_stb) stb_n++;
         if (up_stall) stl_n++;
         if (k == 1) up_stb = 1'b0;
         t = k - 1;
         dn_stall = 1'b0; dn_ack = 1'b0; dn_err = 1'b0; dn_rdata = '0;
         if (dn_cyc) begin
            if (dn_stb && t < stall_n) dn_stall = 1'b1;
            if (kind != 3 && t == tr) begin
               case (kind)
                  0:       dn_ack = 1'b1;
                  1:       dn_err = 1'b1;
                  default: begin dn_ack = 1'b1; dn_err = 1'b1; end
               endcase
               if (kind == 0 && dn_we) ram[dn_addr[6:0]] = dn_wdata;
               dn_rdata = (kind == 0) ? ram[dn_addr[6:0]] : $urandom;
            end
         end
      end
      up_cyc = 1'b0;
      check("resp_cycle", 32'(first), 32'(exp_first));
      check("ack_pulses", 32'(ack_n), 32'(exp_ack));
      check("err_pulses", 32'(err_n), 32'(1 - exp_ack));
      check("dn_cyc_cycles", 32'(cyc_n), 32'(exp_cyc));
      check("dn_stb_cycles", 32'(stb_n), 32'(exp_stb));
      check("stall_cycles", 32'(stl_n), 32'(exp_stl));
      check("data_without_ack", 32'(bad_n), 32'd0);
      check_counters("txn");
   endtask

   task automatic run_abort();
      int resp_n;
      resp_n = 0;
      @(negedge clk);
      up_cyc = 1'b1; up_stb = 1'b1; up_we = 1'b0; up_addr = 32'd5;
      dn_stall = 1'b0; dn_ack = 1'b0; dn_err = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (up_ack || up_err) resp_n++;
         if (k == 1) up_stb = 1'b0;
         if (k == 3) begin
            check("abort_pre_wait", 32'({dn_cyc, dn_stb}), 32'b10);
            up_cyc = 1'b0;
         end
         if (k == 4) begin
            check("abort_dn_cyc", 32'(dn_cyc), 32'd0);
            check("abort_idle_stall", 32'(up_stall), 32'd0);
         end
      end
      check("abort_responses", 32'(resp_n), 32'd0);
      check_counters("abort");
   endtask

   task automatic run_reset_in_req();
      @(negedge clk);
      up_cyc = 1'b1; up_stb = 1'b1; up_we = 1'b1; up_addr = 32'd5; up_wdata = 32'h1234_5678;
      dn_stall = 1'b1;
      @(negedge clk);
      up_stb = 1'b0;
      check("rst_pre_req", 32'({dn_cyc, dn_stb}), 32'b11);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_dn_cyc", 32'(dn_cyc), 32'd0);
      check("rst_mid_outputs", 32'(|{up_ack, up_err, up_stall, up_rdata, dn_cyc, dn_stb,
                                      dn_we, dn_addr, dn_wdata, to_cnt, rej_cnt}), 32'd0);
      up_cyc = 1'b0; dn_stall = 1'b0;
      exp_to = 0; exp_rej = 0;
      @(negedge clk);
      check("rst_no_response", 32'({up_ack, up_err}), 32'd0);
      check_counters("rst");
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] v;
      int stall_n, rdly, kind, sel;
      logic [31:0] addr;
      for (int i = 0; i < 128; i++) begin
         v = $urandom;
         ram[i] = v;
         mem_model[i] = v;
      end
      #1 rst_n = 1'b0;
      #10;
      check("reset_outputs", 32'(|{up_ack, up_err, up_stall, up_rdata, dn_cyc, dn_stb,
                                    dn_we, dn_addr, dn_wdata, to_cnt, rej_cnt}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_txn(1'b1, 32'd5, 32'hDEAD_BEEF, 0, 0, 0);
      run_txn(1'b0, 32'd5, 32'd0, 0, 0, 0);
      run_txn(1'b0, 32'd5, 32'd0, 2, 3, 0);
      run_txn(1'b0, 32'd7, 32'd0, 40, 0, 0);
      run_txn(1'b0, 32'd200, 32'd0, 0, 0, 0);
      run_txn(1'b1, 32'd128, 32'h5555_AAAA, 0, 0, 0);
      run_txn(1'b0, 32'd3, 32'd0, 0, 1, 1);
      run_txn(1'b0, 32'd3, 32'd0, 1, 0, 2);
      run_txn(1'b0, 32'd3, 32'd0, 1, -1, 0);
      run_txn(1'b0, 32'd5, 32'd0, 0, 14, 0);
      run_txn(1'b0, 32'd5, 32'd0, 0, 15, 0);
      run_txn(1'b0, 32'd5, 32'd0, 15, -1, 0);
      run_txn(1'b0, 32'd5, 32'd0, 0, 14, 1);
      run_abort();
      run_txn(1'b0, 32'd5, 32'd0, 0, 0, 0);
      run_reset_in_req();
      run_txn(1'b0, 32'd5, 32'd0, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         addr    = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(128, 300)) : 32'($urandom_range(0, 15));
         stall_n = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
         rdly    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 16)) : int'($urandom_range(0, 5)) - 1;
         sel     = int'($urandom_range(0, 5));
         kind    = (sel <= 2) ? 0 : sel - 2;
         run_txn(1'($urandom_range(0, 1)), addr, $urandom, stall_n, rdly, kind);
      end

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
